// File: rtl/datapath.sv
// Single-cycle MIPS-style datapath: 16-word ROM fetch, decode, ALU, register write-back.
// Latency: one instruction per clock edge; no handshake, the core never stalls.

// Fixed 16-word program store.
// Purely combinational read; no backpressure.
module dp_rom (
  input  logic [3:0]  addr,
  output logic [31:0] instr
);
  always_comb begin
    instr = 32'h0000_0000;
    case (addr)
      4'd0: instr = 32'h2002_0005;   // addi r2,r0,5
      4'd1: instr = 32'h2001_0000;   // addi r1,r0,0
      4'd2: instr = 32'h0061_1820;   // add  r3,r3,r1
      4'd3: instr = 32'h2021_0001;   // addi r1,r1,1
      default: instr = 32'h0000_0000;
    endcase
  end
endmodule

// Main decoder: opcode/funct to write enable, destination select, operand select, ALU op.
// Purely combinational; no backpressure.
module dp_control (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src,
  output logic [2:0] alu_op
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  always_comb begin
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        reg_dst = 1'b1;
        case (funct)
          6'b100000: begin reg_write = 1'b1; alu_op = ALU_ADD; end
          6'b100010: begin reg_write = 1'b1; alu_op = ALU_SUB; end
          6'b100100: begin reg_write = 1'b1; alu_op = ALU_AND; end
          6'b100101: begin reg_write = 1'b1; alu_op = ALU_OR;  end
          6'b101010: begin reg_write = 1'b1; alu_op = ALU_SLT; end
          default:   reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALU_ADD;
      end
      default: reg_write = 1'b0;
    endcase
  end
endmodule

// 32-bit ALU, wrapping arithmetic, no flags.
// Purely combinational; no backpressure.
module dp_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_op,
  output logic [31:0] y
);
  logic [31:0] diff;
  logic        lt;

  assign diff = a - b;
  // Signed less-than from the difference sign, corrected when the operand signs differ.
  assign lt = (a[31] != b[31]) ? a[31] : diff[31];

  always_comb begin
    y = a + b;
    case (alu_op)
      3'd0: y = a + b;
      3'd1: y = diff;
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = {31'd0, lt};
      default: y = a + b;
    endcase
  end
endmodule

// 32x32 register file, two combinational reads, one synchronous write; r0 is hard zero.
// Write lands on the rising edge; reset clears all entries and overrides the write.
module dp_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < 32; n++) registers[n] <= 32'd0;
    end else if (we && (wa != 5'd0)) begin
      registers[wa] <= wd;
    end
  end

  // r0 reads as zero even before the first reset has cleared storage.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

// Core top: fetch at (pc + i) mod 16, execute, write back on the next rising edge.
// Sequencing comes from pc/i only; the same instruction repeats while they hold.
module datapath (
  input  logic [1:0]  i,
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] pc
);
  logic [3:0]  addr;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_ext;
  logic        reg_write;
  logic        reg_dst;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [4:0]  wr_addr;
  logic        unused_pc_hi;

  // Only the low nibble of pc + i matters, so the carry out of bit 3 is dropped.
  assign addr         = pc[3:0] + {2'b00, i};
  assign unused_pc_hi = ^pc[11:4];

  dp_rom rom (
    .addr  (addr),
    .instr (instr)
  );

  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign funct   = instr[5:0];
  assign imm     = instr[15:0];
  assign imm_ext = {{16{imm[15]}}, imm};

  dp_control ctl (
    .op        (op),
    .funct     (funct),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .alu_src   (alu_src),
    .alu_op    (alu_op)
  );

  assign alu_b   = alu_src ? imm_ext : rt_val;
  assign wr_addr = reg_dst ? rd : rt;

  dp_alu alu (
    .a      (rs_val),
    .b      (alu_b),
    .alu_op (alu_op),
    .y      (alu_y)
  );

  dp_regfile r2 (
    .clock (clock),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_val),
    .rd2   (rt_val),
    .we    (reg_write),
    .wa    (wr_addr),
    .wd    (alu_y)
  );
endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: expected register values are queued per step and checked after the edge.
module tb_datapath;
  logic [1:0]  i;
  logic        clock;
  logic        reset;
  logic [11:0] pc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  datapath dut (
    .i     (i),
    .clock (clock),
    .reset (reset),
    .pc    (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input logic [11:0] p, input logic [1:0] ii, input logic r);
    pc    = p;
    i     = ii;
    reset = r;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_reg(input string tag, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.idx = idx;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_all_zero(input string tag);
    for (int n = 0; n < 32; n++) expect_reg(tag, n, 32'd0);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = dut.r2.registers[e.idx];
      total++;
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s r%0d: observed=%08h expected=%08h", e.tag, e.idx, obs, e.val);
      end
    end
  endtask

  initial begin
    int exp_r3;
    pc    = 12'd0;
    i     = 2'd0;
    reset = 1'b1;

    // Reset: every register cleared.
    step(12'd0, 2'd0, 1'b1);
    expect_all_zero("reset");
    check();

    // Loop program.
    step(12'd0, 2'd0, 1'b0);
    expect_reg("loop_init_r2", 2, 32'd5);
    check();
    step(12'd0, 2'd1, 1'b0);
    expect_reg("loop_init_r1", 1, 32'd0);
    expect_reg("loop_init_r3", 3, 32'd0);
    check();
    exp_r3 = 0;
    for (int k = 0; k < 5; k++) begin
      exp_r3 = exp_r3 + k;
      step(12'd0, 2'd2, 1'b0);
      expect_reg("loop_add_r3", 3, exp_r3);
      expect_reg("loop_add_r1", 1, k);
      check();
      step(12'd0, 2'd3, 1'b0);
      expect_reg("loop_inc_r1", 1, k + 1);
      check();
    end
    expect_reg("loop_end_r1", 1, 32'd5);
    expect_reg("loop_end_r2", 2, 32'd5);
    expect_reg("loop_end_r3", 3, 32'd10);
    check();

    // NOP region: nothing changes, r0 stays zero.
    for (int k = 0; k < 4; k++) begin
      step(12'd4, k[1:0], 1'b0);
      expect_reg("nop_r0", 0, 32'd0);
      expect_reg("nop_r1", 1, 32'd5);
      expect_reg("nop_r2", 2, 32'd5);
      expect_reg("nop_r3", 3, 32'd10);
      expect_reg("nop_r31", 31, 32'd0);
      check();
    end
    total++;
    assert (dut.i === 2'd3) else begin
      bad++;
      $error("FAIL port_i: observed=%0d expected=3", dut.i);
    end

    // Address wrap: pc=14,i=2 and pc=0xFFF,i=1 both fetch word 0.
    step(12'd0, 2'd0, 1'b1);
    step(12'd14, 2'd2, 1'b0);
    expect_reg("wrap14_r2", 2, 32'd5);
    expect_reg("wrap14_r1", 1, 32'd0);
    check();
    step(12'd0, 2'd0, 1'b1);
    step(12'hFFF, 2'd1, 1'b0);
    expect_reg("wrapfff_r2", 2, 32'd5);
    check();

    // Repeat execution: addi r1,r1,1 held for three edges.
    step(12'd0, 2'd0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(12'd0, 2'd3, 1'b0);
      expect_reg("repeat_r1", 1, k);
      check();
    end

    // Reset mid-run with r1=3, r3=3.
    step(12'd0, 2'd2, 1'b0);
    expect_reg("pre_rst_r3", 3, 32'd3);
    expect_reg("pre_rst_r1", 1, 32'd3);
    check();
    step(12'd0, 2'd2, 1'b1);
    expect_all_zero("mid_reset");
    check();
    step(12'd0, 2'd2, 1'b0);
    expect_reg("resume_r3", 3, 32'd0);
    expect_reg("resume_r1", 1, 32'd0);
    check();

    // r0 protection across the whole zero-word ROM region.
    for (int a = 4; a < 16; a++) begin
      step(a[11:0], 2'd0, 1'b0);
      expect_reg("r0_protect", 0, 32'd0);
      check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
